// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared constants and state type for the Keccak message padder
//
// Purpose: domain-separation pad bytes, the final pad-bit byte and the padder
// state enumeration used by keccak_padder_param and keccak_pad_word.
package keccak_pkg;

  // Domain-separation byte placed right after the last message byte.
  localparam logic [7:0] KECCAK_DOMAIN = 8'h01;
  localparam logic [7:0] SHA3_DOMAIN   = 8'h06;

  // Closing bit of the multi-rate padding, ORed into the last byte of a block.
  localparam logic [7:0] PAD_FINAL     = 8'h80;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,  // taking message words
    PAD    = 2'd1,  // message ended, filling the block with zero words
    DONE   = 2'd2   // padded block produced, ignore everything until reset
  } padder_state_e;

endpackage

// File: rtl/keccak_pad_word.sv
// rtl/keccak_pad_word.sv - combinational builder for one word of the padded stream
//
// Purpose: produces the word shifted into the block buffer. Byte 0 of a word is
// its most significant byte (big-endian string order).
//   - pad_mode: all-zero filler word.
//   - is_last : bytes below byte_num come from the message, byte byte_num is the
//               domain byte, the rest are zero.
//   - otherwise the message word passes through unchanged.
//   When the word lands in the last slot of a block that carries padding, the
//   closing 0x80 is ORed into its lowest byte.
// Ports:
//   i_in         message word
//   i_byte_num   valid bytes in the last word (0..W/8-1)
//   i_is_last    this word ends the message
//   i_pad_mode   emit a filler word instead of message data
//   i_final_word the word will occupy the final slot of the block
//   o_w          word to write into the block buffer
module keccak_pad_word
  import keccak_pkg::*;
#(
  parameter int         W      = 32,
  parameter logic [7:0] DOMAIN = KECCAK_DOMAIN,
  localparam int        BW     = $clog2(W / 8)
) (
  input  logic [W-1:0]  i_in,
  input  logic [BW-1:0] i_byte_num,
  input  logic          i_is_last,
  input  logic          i_pad_mode,
  input  logic          i_final_word,
  output logic [W-1:0]  o_w
);

  always_comb begin
    o_w = '0;
    if (!i_pad_mode) begin
      for (int b = 0; b < W / 8; b++) begin
        if (!i_is_last || (b < int'(i_byte_num))) begin
          o_w[W-1-8*b -: 8] = i_in[W-1-8*b -: 8];
        end else if (b == int'(i_byte_num)) begin
          o_w[W-1-8*b -: 8] = DOMAIN;
        end
      end
    end
    // Only the block that holds the end of the message gets the closing bit;
    // an ordinary data word in the last slot of an earlier block is untouched.
    if (i_final_word && (i_pad_mode || i_is_last)) begin
      o_w[7:0] = o_w[7:0] | PAD_FINAL;
    end
  end

endmodule

// File: rtl/keccak_padder_param.sv
// rtl/keccak_padder_param.sv - parametrised Keccak/SHA-3 multi-rate message padder
//
// Purpose: packs W-bit message words into RATE-bit blocks, applies multi-rate
// padding with a configurable domain byte and hands each full block to the
// permutation core with an out_ready / f_ack handshake. Messages may span any
// number of blocks; padding lands in the block holding the last word.
// Ports:
//   clk         clock, rising edge
//   reset       synchronous active-high reset
//   in          message word, byte 0 in in[W-1:W-8]
//   in_ready    in/is_last/byte_num valid
//   is_last     this word ends the message
//   byte_num    valid bytes in the last word
//   f_ack       permutation consumed out; frees the buffer
//   buffer_full block buffer full, input not accepted
//   out         padded block, first word in out[RATE-1:RATE-W]
//   out_ready   out holds a complete block
module keccak_padder_param
  import keccak_pkg::*;
#(
  parameter int         W      = 32,
  parameter int         RATE   = 576,
  parameter logic [7:0] DOMAIN = KECCAK_DOMAIN,
  localparam int        NW     = RATE / W,
  localparam int        BW     = $clog2(W / 8),
  localparam int        CW     = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [W-1:0]    in,
  input  logic            in_ready,
  input  logic            is_last,
  input  logic [BW-1:0]   byte_num,
  input  logic            f_ack,
  output logic            buffer_full,
  output logic [RATE-1:0] out,
  output logic            out_ready
);

  padder_state_e   r_state;
  padder_state_e   w_state_nxt;
  logic [RATE-1:0] r_out;
  logic [CW-1:0]   r_cnt;
  logic            r_full;

  logic            w_accept;
  logic            w_pad_write;
  logic            w_write;
  logic            w_final_word;
  logic [W-1:0]    w_word;

  // While the buffer is full nothing is written, including the f_ack cycle.
  assign w_accept     = in_ready && !r_full && (r_state == ACCEPT);
  assign w_pad_write  = (r_state == PAD) && !r_full;
  assign w_write      = w_accept || w_pad_write;
  assign w_final_word = (r_cnt == CW'(NW - 1));

  keccak_pad_word #(
    .W      (W),
    .DOMAIN (DOMAIN)
  ) u_pad_word (
    .i_in         (in),
    .i_byte_num   (byte_num),
    .i_is_last    (is_last),
    .i_pad_mode   (w_pad_write),
    .i_final_word (w_final_word),
    .o_w          (w_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ACCEPT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCEPT: begin
        // A last word in the final slot already carries the closing bit, so
        // there is nothing left to pad.
        if (w_accept && is_last) begin
          w_state_nxt = w_final_word ? DONE : PAD;
        end
      end
      PAD: begin
        if (w_pad_write && w_final_word) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = DONE;
      end
      default: begin
        w_state_nxt = ACCEPT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out  <= '0;
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else if (r_full) begin
      if (f_ack) begin
        r_out  <= '0;
        r_cnt  <= '0;
        r_full <= 1'b0;
      end
    end else if (w_write) begin
      r_out <= {r_out[RATE-W-1:0], w_word};
      // The count parks at NW-1 while full; f_ack brings it back to zero.
      if (w_final_word) begin
        r_full <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign out         = r_out;
  assign buffer_full = r_full;
  assign out_ready   = r_full;

endmodule

// File: tb/tb_keccak_padder_param.sv
// tb/tb_keccak_padder_param.sv - self-checking bench for keccak_padder_param
module tb_keccak_padder_param;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // 32-bit / 576-bit Keccak instance
  logic [31:0]   in32 = '0;
  logic          rdy32 = 1'b0, last32 = 1'b0, ack32 = 1'b0;
  logic [1:0]    bn32 = '0;
  logic          full32, ordy32;
  logic [575:0]  out32;

  // 64-bit / 1088-bit SHA-3 instance
  logic [63:0]   in64 = '0;
  logic          rdy64 = 1'b0, last64 = 1'b0, ack64 = 1'b0;
  logic [2:0]    bn64 = '0;
  logic          full64, ordy64;
  logic [1087:0] out64;

  keccak_padder_param #(.W(32), .RATE(576), .DOMAIN(8'h01)) dut32 (
    .clk(clk), .reset(reset), .in(in32), .in_ready(rdy32), .is_last(last32),
    .byte_num(bn32), .f_ack(ack32), .buffer_full(full32), .out(out32),
    .out_ready(ordy32)
  );

  keccak_padder_param #(.W(64), .RATE(1088), .DOMAIN(8'h06)) dut64 (
    .clk(clk), .reset(reset), .in(in64), .in_ready(rdy64), .is_last(last64),
    .byte_num(bn64), .f_ack(ack64), .buffer_full(full64), .out(out64),
    .out_ready(ordy64)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_blk32(input string name, input logic [575:0] act, input logic [575:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      for (int j = 0; j < 18; j++) begin
        if (act[575-32*j -: 32] !== exp[575-32*j -: 32]) begin
          $display("FAIL %s: word %0d got %08h want %08h", name, j,
                   act[575-32*j -: 32], exp[575-32*j -: 32]);
          break;
        end
      end
    end
  endtask

  task automatic check_blk64(input string name, input logic [1087:0] act, input logic [1087:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      for (int j = 0; j < 17; j++) begin
        if (act[1087-64*j -: 64] !== exp[1087-64*j -: 64]) begin
          $display("FAIL %s: word %0d got %016h want %016h", name, j,
                   act[1087-64*j -: 64], exp[1087-64*j -: 64]);
          break;
        end
      end
    end
  endtask

  function automatic logic [575:0] put32(input logic [575:0] b, input int j, input logic [31:0] v);
    b[575-32*j -: 32] = v;
    return b;
  endfunction

  function automatic logic [1087:0] put64(input logic [1087:0] b, input int j, input logic [63:0] v);
    b[1087-64*j -: 64] = v;
    return b;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic send32(input logic [31:0] d, input logic l, input logic [1:0] b);
    in32 = d; last32 = l; bn32 = b; rdy32 = 1'b1;
    step();
    rdy32 = 1'b0; last32 = 1'b0;
  endtask

  task automatic send64(input logic [63:0] d, input logic l, input logic [2:0] b);
    in64 = d; last64 = l; bn64 = b; rdy64 = 1'b1;
    step();
    rdy64 = 1'b0; last64 = 1'b0;
  endtask

  // Counts the is_last accept edge as cycle 1; bounded so a stuck DUT still ends.
  task automatic wait_ready32(output int cyc);
    cyc = 1;
    while (!ordy32 && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  task automatic wait_ready64(output int cyc);
    cyc = 1;
    while (!ordy64 && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  typedef struct {
    int          k;         // "aaaa" words before the last word
    logic [31:0] data;      // last word as presented
    logic [1:0]  bn;        // byte_num
    logic [31:0] exp_last;  // padded last word
    int          exp_cyc;   // cycles from is_last to out_ready
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [575:0]  e32;
    logic [1087:0] e64;
    int            cyc;

    tbl[0] = '{k: 0,  data: 32'hDEADBEEF, bn: 2'd0, exp_last: 32'h01000000, exp_cyc: 18};
    tbl[1] = '{k: 0,  data: 32'h61626300, bn: 2'd2, exp_last: 32'h61620100, exp_cyc: 18};
    tbl[2] = '{k: 5,  data: 32'h11223344, bn: 2'd1, exp_last: 32'h11010000, exp_cyc: 13};
    tbl[3] = '{k: 16, data: 32'h41424344, bn: 2'd3, exp_last: 32'h41424301, exp_cyc: 2};
    tbl[4] = '{k: 17, data: 32'h61626364, bn: 2'd3, exp_last: 32'h61626381, exp_cyc: 1};
    tbl[5] = '{k: 17, data: 32'h12345678, bn: 2'd0, exp_last: 32'h01000080, exp_cyc: 1};
    tbl[6] = '{k: 16, data: 32'h99999999, bn: 2'd0, exp_last: 32'h01000000, exp_cyc: 2};

    // Reset with a word offered: nothing may be accepted.
    step();
    reset = 1'b1; rdy32 = 1'b1; in32 = 32'hFFFFFFFF;
    step();
    check("reset_out", {63'd0, |out32}, 64'd0);
    check("reset_full", {63'd0, full32}, 64'd0);
    check("reset_ready", {63'd0, ordy32}, 64'd0);
    reset = 1'b0; rdy32 = 1'b0;

    // Table-driven single-block messages on the 32/576 instance.
    for (int t = 0; t < 7; t++) begin
      do_reset();
      for (int i = 0; i < tbl[t].k; i++) send32(32'h61616161, 1'b0, 2'd0);
      send32(tbl[t].data, 1'b1, tbl[t].bn);
      wait_ready32(cyc);
      check($sformatf("tbl%0d_cycles", t), 64'(cyc), 64'(tbl[t].exp_cyc));
      e32 = '0;
      for (int i = 0; i < tbl[t].k; i++) e32 = put32(e32, i, 32'h61616161);
      e32 = put32(e32, tbl[t].k, tbl[t].exp_last);
      if (tbl[t].k != 17) e32 = put32(e32, 17, 32'h00000080);
      check_blk32($sformatf("tbl%0d_block", t), out32, e32);
      ack32 = 1'b1;
      step();
      ack32 = 1'b0;
      check($sformatf("tbl%0d_acked", t), {63'd0, full32}, 64'd0);
    end

    // Multi-block with backpressure, then DONE.
    do_reset();
    for (int i = 0; i < 18; i++) send32(32'h1000 + 32'(i), 1'b0, 2'd0);
    check("mb_full", {62'd0, full32, ordy32}, 64'd3);
    e32 = '0;
    for (int i = 0; i < 18; i++) e32 = put32(e32, i, 32'h1000 + 32'(i));
    check_blk32("mb_block1", out32, e32);
    in32 = 32'hCAFE0013; rdy32 = 1'b1;
    step(); step(); step();
    check_blk32("mb_held", out32, e32);
    ack32 = 1'b1;
    step();
    ack32 = 1'b0;
    check("mb_ack_no_accept", {62'd0, |out32, full32}, 64'd0);
    step();
    rdy32 = 1'b0;
    check("mb_w19_accepted", 64'(out32[31:0]), 64'hCAFE0013);
    send32(32'h77777777, 1'b1, 2'd0);
    wait_ready32(cyc);
    check("mb_cycles", 64'(cyc), 64'd17);
    e32 = '0;
    e32 = put32(e32, 0, 32'hCAFE0013);
    e32 = put32(e32, 1, 32'h01000000);
    e32 = put32(e32, 17, 32'h00000080);
    check_blk32("mb_block2", out32, e32);
    ack32 = 1'b1;
    step();
    ack32 = 1'b0;
    in32 = 32'h55555555; rdy32 = 1'b1; last32 = 1'b1;
    for (int i = 0; i < 20; i++) step();
    rdy32 = 1'b0; last32 = 1'b0;
    check("done_ignores", {62'd0, |out32, full32}, 64'd0);

    // Mid-block reset, with stray f_ack before and f_ack/in_ready during reset.
    do_reset();
    for (int i = 0; i < 5; i++) send32(32'h100 + 32'(i), 1'b0, 2'd0);
    ack32 = 1'b1;
    step();
    ack32 = 1'b0;
    check("stray_ack_ignored", 64'(out32[63:0]), 64'h0000010300000104);
    reset = 1'b1; rdy32 = 1'b1; ack32 = 1'b1; in32 = 32'hFFFFFFFF;
    step();
    reset = 1'b0; rdy32 = 1'b0; ack32 = 1'b0;
    check("midreset_clear", {63'd0, |out32}, 64'd0);
    send32(32'h48656c6c, 1'b0, 2'd0);
    send32(32'h6f2c2077, 1'b0, 2'd0);
    send32(32'h6f726c64, 1'b0, 2'd0);
    send32(32'h00000000, 1'b1, 2'd0);
    wait_ready32(cyc);
    check("midreset_cycles", 64'(cyc), 64'd15);
    e32 = '0;
    e32 = put32(e32, 0, 32'h48656c6c);
    e32 = put32(e32, 1, 32'h6f2c2077);
    e32 = put32(e32, 2, 32'h6f726c64);
    e32 = put32(e32, 3, 32'h01000000);
    e32 = put32(e32, 17, 32'h00000080);
    check_blk32("midreset_block", out32, e32);

    // SHA-3 64/1088: "Hello, world!"
    do_reset();
    send64(64'h48656c6c6f2c2077, 1'b0, 3'd0);
    send64(64'h6f726c6421ffffff, 1'b1, 3'd5);
    wait_ready64(cyc);
    check("sha3_cycles", 64'(cyc), 64'd16);
    check("sha3_word1", out64[1023:960], 64'h6f726c6421060000);
    check("sha3_tail", 64'(out64[7:0]), 64'h80);
    e64 = '0;
    e64 = put64(e64, 0, 64'h48656c6c6f2c2077);
    e64 = put64(e64, 1, 64'h6f726c6421060000);
    e64 = put64(e64, 16, 64'h0000000000000080);
    check_blk64("sha3_block", out64, e64);

    // SHA-3 last word filling the final slot with a full byte count: 0x86.
    do_reset();
    for (int i = 0; i < 16; i++) send64(64'h6161616161616161, 1'b0, 3'd0);
    send64(64'h0102030405060708, 1'b1, 3'd7);
    wait_ready64(cyc);
    check("sha3_full_cycles", 64'(cyc), 64'd1);
    check("sha3_full_last", out64[63:0], 64'h0102030405060786);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
